rf_read_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's two combinational read ports (rs1/rs2) among `NUM_REQ` issue-stage requesters (reservation-station dispatch slots). Each cycle it grants at most one requester, drives that requester's source indices to the register file, and merges a same-cycle commit write into the read data. It returns both operands through a registered, back-pressurable response port. It sits between the reservation-station schedulers and the register file. The commit stage keeps sole ownership of the register file write port.

---
 rtl/rf_read_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_read_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the register file's rs1/rs2 read ports among
// NUM_REQ dispatch slots, with commit-write bypass and a registered response.
module rf_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_rs1,
  input  logic [5*NUM_REQ-1:0] req_rs2,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [31:0]          rf_rs1_data,
  input  logic [31:0]          rf_rs2_data,
  input  logic                 cm_regwrite,
  input  logic [4:0]           cm_rd,
  input  logic [31:0]          cm_wdata,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_rs1_data,
  output logic [31:0]          resp_rs2_data,
  input  logic                 resp_ready
);

  logic [4:0] rs1_arr [NUM_REQ];
  logic [4:0] rs2_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign rs1_arr[gi] = req_rs1[5*gi +: 5];
      assign rs2_arr[gi] = req_rs2[5*gi +: 5];
    end
  endgenerate

  logic            resp_valid_reg;
  logic [ID_W-1:0] resp_id_reg;
  logic [31:0]     resp_rs1_data_reg;
  logic [31:0]     resp_rs2_data_reg;
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;

  logic               can_load;
  logic               grant_en;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_oh;
  int                 idx;

  assign can_load = !resp_valid_reg || resp_ready;
  assign grant_en = can_load && !flush && !reset;

  // Search upward from ptr with wrap; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (grant_en && !grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (grant_any) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready = grant_oh;

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) ptr_next = '0;
      else                                ptr_next = grant_id + ID_W'(1);
    end
  end

  assign rf_rs1 = grant_any ? rs1_arr[grant_id] : 5'd0;
  assign rf_rs2 = grant_any ? rs2_arr[grant_id] : 5'd0;

  // The register file captures the commit write at this same edge, so its
  // read data is stale for a matching index; forward the write instead.
  logic        byp1;
  logic        byp2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign byp1 = cm_regwrite && (cm_rd != 5'd0) && (cm_rd == rf_rs1);
  assign byp2 = cm_regwrite && (cm_rd != 5'd0) && (cm_rd == rf_rs2);

  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (rf_rs1 == 5'd0) rs1_val = 32'd0;
    else if (byp1)      rs1_val = cm_wdata;
    if (rf_rs2 == 5'd0) rs2_val = 32'd0;
    else if (byp2)      rs2_val = cm_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg           <= '0;
      resp_valid_reg    <= 1'b0;
      resp_id_reg       <= '0;
      resp_rs1_data_reg <= 32'd0;
      resp_rs2_data_reg <= 32'd0;
    end else begin
      ptr_reg <= ptr_next;
      if (grant_any) begin
        resp_valid_reg    <= 1'b1;
        resp_id_reg       <= grant_id;
        resp_rs1_data_reg <= rs1_val;
        resp_rs2_data_reg <= rs2_val;
      end else if (resp_ready || flush) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign resp_valid    = resp_valid_reg;
  assign resp_id       = resp_id_reg;
  assign resp_rs1_data = resp_rs1_data_reg;
  assign resp_rs2_data = resp_rs2_data_reg;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops them as responses are accepted.
module tb_rf_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_rs1;
  logic [19:0] req_rs2;
  logic [3:0]  req_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        cm_regwrite = 1'b0;
  logic [4:0]  cm_rd = '0;
  logic [31:0] cm_wdata = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_rs1_data, resp_rs2_data;
  logic        resp_ready = 1'b0;

  logic [4:0]  rs1_t [4];
  logic [4:0]  rs2_t [4];
  logic [31:0] regs  [32];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_read_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ready(req_ready),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .cm_regwrite(cm_regwrite), .cm_rd(cm_rd), .cm_wdata(cm_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rs1_data(resp_rs1_data),
    .resp_rs2_data(resp_rs2_data), .resp_ready(resp_ready)
  );

  always_comb begin
    req_rs1 = '0;
    req_rs2 = '0;
    for (int k = 0; k < 4; k++) begin
      req_rs1[5*k +: 5] = rs1_t[k];
      req_rs2[5*k +: 5] = rs2_t[k];
    end
  end

  // Register file model: combinational read, write captured at the edge.
  assign rf_rs1_data = regs[rf_rs1];
  assign rf_rs2_data = regs[rf_rs2];

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) regs[r] <= (r == 0) ? 32'd0 : 32'h1000 + r;
      regs[3] <= 32'h11;
      regs[4] <= 32'h22;
      regs[5] <= 32'h1;
    end else if (cm_regwrite && cm_rd != 5'd0) begin
      regs[cm_rd] <= cm_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with the given request vector; checks the grant and, if one
  // is expected, queues the response it must produce.
  task automatic grant_cycle(input logic [3:0] valid, input logic [3:0] exp_rdy,
                             input logic [1:0] id, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    req_valid = valid;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e.id = id; e.d1 = d1; e.d2 = d2;
      sb.push_back(e);
    end
    step();
  endtask

  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got id=%0d rs1=0x%08h rs2=0x%08h expected none",
                 resp_id, resp_rs1_data, resp_rs2_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_id !== e.id || resp_rs1_data !== e.d1 || resp_rs2_data !== e.d2) begin
          n_fail++;
          $display("FAIL resp: got id=%0d rs1=0x%08h rs2=0x%08h expected id=%0d rs1=0x%08h rs2=0x%08h",
                   resp_id, resp_rs1_data, resp_rs2_data, e.id, e.d1, e.d2);
        end else begin
          $display("resp id=%0d rs1=0x%08h rs2=0x%08h", resp_id, resp_rs1_data, resp_rs2_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rs1_t[k] = 5'(8 + k);
      rs2_t[k] = 5'(16 + k);
    end

    // Reset with requests pending: no grants, zero addresses, reset state.
    req_valid = 4'b1111;
    step();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rf_rs1", 32'(rf_rs1), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_rs1", resp_rs1_data, 32'h0);
    check("rst_resp_rs2", resp_rs2_data, 32'h0);
    step();
    reset = 1'b0;
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    step();

    // Single request from slot 2.
    rs1_t[2] = 5'd3;
    rs2_t[2] = 5'd4;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_rf_rs1", 32'(rf_rs1), 32'd3);
    check("single_rf_rs2", 32'(rf_rs2), 32'd4);
    step();
    rs1_t[2] = 5'd10;
    rs2_t[2] = 5'd18;
    sb.push_back('{id: 2'd2, d1: 32'h11, d2: 32'h22});
    req_valid = 4'b0000;
    step();

    // Round robin from ptr=3: 3,0,1,2,3,0.
    grant_cycle(4'b1111, 4'b1000, 2'd3, 32'h100b, 32'h1013);
    grant_cycle(4'b1111, 4'b0001, 2'd0, 32'h1008, 32'h1010);
    grant_cycle(4'b1111, 4'b0010, 2'd1, 32'h1009, 32'h1011);
    grant_cycle(4'b1111, 4'b0100, 2'd2, 32'h100a, 32'h1012);
    grant_cycle(4'b1111, 4'b1000, 2'd3, 32'h100b, 32'h1013);
    grant_cycle(4'b1111, 4'b0001, 2'd0, 32'h1008, 32'h1010);

    // Back-pressure for 3 cycles holding the slot-0 response.
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_resp_valid", 32'(resp_valid), 32'h1);
      check("bp_resp_id", 32'(resp_id), 32'h0);
      check("bp_resp_rs1", resp_rs1_data, 32'h1008);
      step();
    end
    resp_ready = 1'b1;
    grant_cycle(4'b1111, 4'b0010, 2'd1, 32'h1009, 32'h1011);

    // Commit bypass on rs1, then on rs2, then the x0 guard.
    cm_regwrite = 1'b1;
    cm_rd = 5'd5;
    cm_wdata = 32'hDEADBEEF;
    rs1_t[0] = 5'd5;
    rs2_t[0] = 5'd0;
    grant_cycle(4'b0001, 4'b0001, 2'd0, 32'hDEADBEEF, 32'h0);
    cm_rd = 5'd9;
    cm_wdata = 32'hCAFEF00D;
    rs1_t[1] = 5'd7;
    rs2_t[1] = 5'd9;
    grant_cycle(4'b0010, 4'b0010, 2'd1, 32'h1007, 32'hCAFEF00D);
    cm_rd = 5'd0;
    cm_wdata = 32'hFFFFFFFF;
    rs1_t[3] = 5'd0;
    rs2_t[3] = 5'd6;
    grant_cycle(4'b1000, 4'b1000, 2'd3, 32'h0, 32'h1006);
    cm_regwrite = 1'b0;

    // Flush while stalled drops the response; flush alone blocks grants.
    rs1_t[2] = 5'd3;
    rs2_t[2] = 5'd4;
    grant_cycle(4'b0100, 4'b0100, 2'd2, 32'h11, 32'h22);
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    check("fl_stall_valid", 32'(resp_valid), 32'h1);
    check("fl_stall_ready", 32'(req_ready), 32'h0);
    step();
    flush = 1'b1;
    @(negedge clk);
    check("fl_req_ready", 32'(req_ready), 32'h0);
    void'(sb.pop_back());
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    check("fl_resp_valid", 32'(resp_valid), 32'h0);
    check("fl_only_ready", 32'(req_ready), 32'h0);
    step();
    flush = 1'b0;
    grant_cycle(4'b0001, 4'b0001, 2'd0, 32'hDEADBEEF, 32'h0);

    // Reset mid-stall: pending response dropped and ptr back to 0.
    for (int k = 0; k < 4; k++) begin
      rs1_t[k] = 5'(8 + k);
      rs2_t[k] = 5'(16 + k);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    check("rs_pre_grant", 32'(req_ready), 32'h2);
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    check("rs_stall_valid", 32'(resp_valid), 32'h1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rs_req_ready", 32'(req_ready), 32'h0);
    check("rs_rf_rs2", 32'(rf_rs2), 32'h0);
    step();
    reset = 1'b0;
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    @(negedge clk);
    check("rs_resp_valid", 32'(resp_valid), 32'h0);
    check("rs_resp_id", 32'(resp_id), 32'h0);
    check("rs_resp_rs1", resp_rs1_data, 32'h0);
    check("rs_resp_rs2", resp_rs2_data, 32'h0);
    step();
    grant_cycle(4'b1111, 4'b0001, 2'd0, 32'h1008, 32'h1010);
    req_valid = 4'b0000;
    step();
    step();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
